// File: rtl/caesar_cipher_engine.sv
// Streaming Caesar-cipher core: external valid/ready or auto-stepping counter source,
// combinational modular shift, single registered result stage with backpressure.
module caesar_cipher_engine #(
    parameter int ALPHA    = 26,
    parameter int WIDTH    = 5,
    parameter int TICK_DIV = 50000000
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             ENCRYPT,
    input  logic [WIDTH-1:0] key,
    input  logic             auto_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sym,
    output logic [WIDTH-1:0] out_src,
    output logic             out_err,
    output logic [WIDTH-1:0] auto_sym
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   ALPHA_X  = (WIDTH + 1)'(ALPHA);
    localparam logic [WIDTH-1:0] SYM_LAST = WIDTH'(ALPHA - 1);

    typedef struct packed {
        logic [WIDTH-1:0] sym;
        logic [WIDTH-1:0] src;
        logic             err;
    } result_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             pending;
    logic             load_ok;
    logic             auto_load;
    logic             ext_load;
    result_t          res_q;
    result_t          res_d;
    logic [WIDTH-1:0] src_sym;
    logic [WIDTH:0]   s_x;
    logic [WIDTH:0]   k_x;
    logic [WIDTH:0]   t_x;
    logic             key_bad;
    logic             sym_bad;

    assign tick      = (div_cnt == DIV_LAST);
    assign load_ok   = !out_valid | out_ready;
    // Gated by rst so the stream sees no acceptance while the core is held in reset.
    assign in_ready  = rst & load_ok & !auto_en;
    assign ext_load  = in_valid & in_ready;
    assign auto_load = pending & load_ok & auto_en;

    assign out_sym = res_q.sym;
    assign out_src = res_q.src;
    assign out_err = res_q.err;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        src_sym = auto_en ? auto_sym : in_sym;
        s_x     = {1'b0, src_sym};
        key_bad = ({1'b0, key} >= ALPHA_X);
        sym_bad = (s_x >= ALPHA_X);
        k_x     = key_bad ? '0 : {1'b0, key};
        if (ENCRYPT) begin
            t_x = s_x + k_x;
        end else begin
            t_x = s_x + ALPHA_X - k_x;
        end
        if (t_x >= ALPHA_X) begin
            t_x = t_x - ALPHA_X;
        end
        res_d.sym = sym_bad ? src_sym : t_x[WIDTH-1:0];
        res_d.src = src_sym;
        res_d.err = key_bad | sym_bad;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Single pending slot: a tick landing on the clearing load keeps it set.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (!auto_en) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end else if (auto_load) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            auto_sym <= '0;
        end else if (auto_load) begin
            auto_sym <= (auto_sym == SYM_LAST) ? '0 : auto_sym + WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            res_q     <= '0;
        end else if (ext_load | auto_load) begin
            out_valid <= 1'b1;
            res_q     <= res_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_caesar_cipher_engine.sv
// Scoreboard bench for caesar_cipher_engine (ALPHA=26, WIDTH=5, TICK_DIV=4).
module tb_caesar_cipher_engine;

    localparam int ALPHA    = 26;
    localparam int WIDTH    = 5;
    localparam int TICK_DIV = 4;

    typedef struct {
        logic [WIDTH-1:0] sym;
        logic [WIDTH-1:0] src;
        logic             err;
    } exp_t;

    logic             CLOCK_50;
    logic             rst;
    logic             ENCRYPT;
    logic [WIDTH-1:0] key;
    logic             auto_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sym;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sym;
    logic [WIDTH-1:0] out_src;
    logic             out_err;
    logic [WIDTH-1:0] auto_sym;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc;
    int   tests;
    int   fails;
    exp_t mon_e;

    caesar_cipher_engine #(
        .ALPHA(ALPHA), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .ENCRYPT(ENCRYPT), .key(key),
        .auto_en(auto_en), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_src(out_src), .out_err(out_err), .auto_sym(auto_sym)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic exp_t model(input int s, input int k, input bit enc);
        exp_t e;
        int   kk;
        e.src = WIDTH'(s);
        e.err = 1'b0;
        kk    = k;
        if (kk >= ALPHA) begin
            kk    = 0;
            e.err = 1'b1;
        end
        if (s >= ALPHA) begin
            e.sym = WIDTH'(s);
            e.err = 1'b1;
        end else if (enc) begin
            e.sym = WIDTH'((s + kk) % ALPHA);
        end else begin
            e.sym = WIDTH'((s - kk + ALPHA) % ALPHA);
        end
        return e;
    endfunction

    // Consumer side: every handshake pops one expected result.
    always @(negedge CLOCK_50) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got sym=%0d src=%0d err=%0d, none expected",
                         out_sym, out_src, out_err);
            end else begin
                mon_e = sb.pop_front();
                if (out_sym !== mon_e.sym || out_src !== mon_e.src || out_err !== mon_e.err) begin
                    fails++;
                    $display("FAIL result: got sym=%0d src=%0d err=%0d, want sym=%0d src=%0d err=%0d",
                             out_sym, out_src, out_err, mon_e.sym, mon_e.src, mon_e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int s, output int waited);
        bit accepted;
        accepted = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_sym   = WIDTH'(s);
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge CLOCK_50);
            if (in_ready === 1'b1) begin
                sb.push_back(model(s, int'(key), ENCRYPT));
                accepted = 1'b1;
            end else begin
                waited++;
            end
            @(posedge CLOCK_50);
            #1;
        end
        tests++;
        if (!accepted) begin
            fails++;
            $display("FAIL accept_timeout: symbol %0d not accepted, want accepted within 20 cycles", s);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge CLOCK_50);
            #1;
            if (sb.size() == 0) break;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ENCRYPT = 1'b1; key = '0; auto_en = 1'b0;
        in_valid = 1'b0; in_sym = '0; out_ready = 1'b1;
        #2;
        tests++;
        if ({out_valid, out_sym, out_src, out_err, auto_sym, in_ready} !== '0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b sym=%0d src=%0d err=%b auto=%0d rdy=%b, want all 0",
                     out_valid, out_sym, out_src, out_err, auto_sym, in_ready);
        end
        @(posedge CLOCK_50);
        #1;
        rst = 1'b1;
        @(negedge CLOCK_50);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, want 1", in_ready);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_encrypt_stream();
        int w;
        int syms[3] = '{0, 22, 25};
        ENCRYPT = 1'b1; key = 5'd3; out_ready = 1'b1;
        pop_cyc.delete();
        foreach (syms[i]) begin
            send(syms[i], w);
            tests++;
            if (w != 0) begin
                fails++;
                $display("FAIL stream_ready: symbol %0d waited %0d cycles, want 0", syms[i], w);
            end
        end
        in_valid = 1'b0;
        wait_drain(10);
        tests++;
        if (pop_cyc.size() != 3 || pop_cyc[1] - pop_cyc[0] != 1 || pop_cyc[2] - pop_cyc[1] != 1) begin
            fails++;
            $display("FAIL stream_throughput: got %0d results not in consecutive cycles, want 3 consecutive",
                     pop_cyc.size());
        end
    endtask

    task automatic test_decrypt();
        int w;
        ENCRYPT = 1'b0; key = 5'd5;
        send(2, w);
        key = 5'd0;
        send(25, w);
        in_valid = 1'b0;
        wait_drain(10);
    endtask

    task automatic test_out_of_range();
        int w;
        ENCRYPT = 1'b1; key = 5'd27;
        send(4, w);
        key = 5'd1;
        send(30, w);
        in_valid = 1'b0;
        wait_drain(10);
    endtask

    task automatic test_backpressure();
        int   w;
        exp_t hold;
        exp_t nxt;
        out_ready = 1'b0; ENCRYPT = 1'b1; key = 5'd3;
        hold = model(10, 3, 1'b1);
        send(10, w);
        in_valid = 1'b0;
        key = 5'd7; ENCRYPT = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge CLOCK_50);
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_ready: got %b, want 0", in_ready);
            end
            tests++;
            if (out_valid !== 1'b1 || out_sym !== hold.sym || out_src !== hold.src || out_err !== hold.err) begin
                fails++;
                $display("FAIL hold_stable: got valid=%b sym=%0d src=%0d err=%b, want 1 %0d %0d %b",
                         out_valid, out_sym, out_src, out_err, hold.sym, hold.src, hold.err);
            end
            @(posedge CLOCK_50);
            #1;
        end
        nxt = model(5, 7, 1'b0);
        in_valid = 1'b1; in_sym = 5'd5; out_ready = 1'b1;
        @(negedge CLOCK_50);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL pass_ready: got %b, want 1", in_ready);
        end else begin
            sb.push_back(nxt);
        end
        @(posedge CLOCK_50);
        #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge CLOCK_50);
        tests++;
        if (out_valid !== 1'b1 || out_sym !== nxt.sym || sb.size() != 1) begin
            fails++;
            $display("FAIL pass_through: got valid=%b sym=%0d queued=%0d, want 1 %0d 1",
                     out_valid, out_sym, sb.size(), nxt.sym);
        end
        @(posedge CLOCK_50);
        #1;
        out_ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_auto();
        out_ready = 1'b1; key = 5'd1; ENCRYPT = 1'b1;
        pop_cyc.delete();
        for (int i = 0; i < 27; i++) sb.push_back(model(i % ALPHA, 1, 1'b1));
        auto_en = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL auto_blocks_stream: got in_ready=%b, want 0", in_ready);
        end
        wait_drain(27 * TICK_DIV + 20);
        tests++;
        if (pop_cyc.size() != 27) begin
            fails++;
            $display("FAIL auto_count: got %0d results, want 27", pop_cyc.size());
        end
        for (int i = 1; i < pop_cyc.size(); i++) begin
            tests++;
            if (pop_cyc[i] - pop_cyc[i-1] != TICK_DIV) begin
                fails++;
                $display("FAIL auto_rate: result %0d interval %0d, want %0d",
                         i, pop_cyc[i] - pop_cyc[i-1], TICK_DIV);
            end
        end
        // Stall the consumer: only one result may be taken, later ticks collapse into one pending.
        out_ready = 1'b0;
        repeat (12) @(posedge CLOCK_50);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_src !== 5'd1 || out_sym !== 5'd2 || auto_sym !== 5'd2) begin
            fails++;
            $display("FAIL auto_hold: got valid=%b src=%0d sym=%0d auto=%0d, want 1 1 2 2",
                     out_valid, out_src, out_sym, auto_sym);
        end
        pop_cyc.delete();
        sb.push_back(model(1, 1, 1'b1));
        sb.push_back(model(2, 1, 1'b1));
        sb.push_back(model(3, 1, 1'b1));
        out_ready = 1'b1;
        wait_drain(20);
        tests++;
        if (pop_cyc.size() != 3 || pop_cyc[1] - pop_cyc[0] != 1 || pop_cyc[2] - pop_cyc[1] != 2) begin
            fails++;
            $display("FAIL auto_drop: got %0d results with intervals not 1,2, want pending slot of one",
                     pop_cyc.size());
        end
        auto_en = 1'b0;
        repeat (8) @(posedge CLOCK_50);
        #1;
        tests++;
        if (out_valid !== 1'b0 || auto_sym !== 5'd4) begin
            fails++;
            $display("FAIL auto_off: got valid=%b auto=%0d, want 0 4", out_valid, auto_sym);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int c0;
        seen = 1'b0;
        out_ready = 1'b0; auto_en = 1'b1;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(posedge CLOCK_50);
            #1;
            seen = (out_valid === 1'b1);
        end
        repeat (5) @(posedge CLOCK_50);
        #2;
        tests++;
        if (out_valid !== 1'b1 || out_src === 5'd0) begin
            fails++;
            $display("FAIL mid_setup: got valid=%b src=%0d, want 1 and nonzero", out_valid, out_src);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_sym, out_src, out_err, auto_sym, in_ready} !== '0) begin
            fails++;
            $display("FAIL async_reset: got valid=%b sym=%0d src=%0d err=%b auto=%0d rdy=%b, want all 0",
                     out_valid, out_sym, out_src, out_err, auto_sym, in_ready);
        end
        out_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        c0 = cyc;
        rst = 1'b1;
        pop_cyc.delete();
        sb.push_back(model(0, 1, 1'b1));
        wait_drain(20);
        tests++;
        if (pop_cyc.size() != 1 || pop_cyc[0] - c0 != TICK_DIV + 1) begin
            fails++;
            $display("FAIL first_tick: got %0d results, first at +%0d cycles, want 1 at +%0d",
                     pop_cyc.size(), (pop_cyc.size() > 0) ? pop_cyc[0] - c0 : -1, TICK_DIV + 1);
        end
        auto_en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_encrypt_stream();
        test_decrypt();
        test_out_of_range();
        test_backpressure();
        test_auto();
        test_reset_mid();
        repeat (3) @(posedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
